// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data RAM between the CPU MEM stage (fixed priority)
// and a debug/loader master. A starvation guard forces one debug slot when the CPU keeps winning.
module dmem_port_arbiter #(
  parameter int AW           = 6,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cpu_rd,
  input  logic          i_cpu_wr,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_stall,
  output logic          o_cpu_rvalid,
  output logic [DW-1:0] o_cpu_rdata,
  input  logic          i_dbg_req,
  input  logic          i_dbg_we,
  input  logic [AW-1:0] i_dbg_addr,
  input  logic [DW-1:0] i_dbg_wdata,
  output logic          o_dbg_gnt,
  output logic          o_dbg_rvalid,
  output logic [DW-1:0] o_dbg_rdata,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  output logic          o_ram_wren,
  input  logic [DW-1:0] i_ram_q,
  output logic [15:0]   o_stat_forced
);

  typedef enum logic {ST_ARB, ST_FORCE} state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t        r_state;
  state_t        w_stateNext;
  logic [7:0]    r_waitCnt;
  logic [7:0]    w_waitNext;
  logic          r_cpuTag;
  logic          r_dbgTag;
  logic [15:0]   r_statForced;
  logic          w_cpuAct;
  logic          w_cGrant;
  logic          w_dGrant;
  logic          w_stall;
  logic          w_forceHit;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_wren;

  assign w_cpuAct = i_cpu_rd | i_cpu_wr;

  always_comb begin
    w_stateNext = r_state;
    w_waitNext  = r_waitCnt;
    w_cGrant    = 1'b0;
    w_dGrant    = 1'b0;
    w_stall     = 1'b0;
    w_forceHit  = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    w_wren      = 1'b0;
    case (r_state)
      ST_ARB: begin
        if (w_cpuAct) begin
          w_cGrant   = 1'b1;
          w_addr     = i_cpu_addr;
          w_wdata    = i_cpu_wdata;
          w_wren     = i_cpu_wr;
          w_waitNext = i_dbg_req ? (r_waitCnt + 8'd1) : 8'd0;
          if (i_dbg_req && (w_waitNext == LIMIT)) begin
            w_stateNext = ST_FORCE;
          end
        end else if (i_dbg_req) begin
          w_dGrant   = 1'b1;
          w_addr     = i_dbg_addr;
          w_wdata    = i_dbg_wdata;
          w_wren     = i_dbg_we;
          w_waitNext = 8'd0;
        end else begin
          w_waitNext = 8'd0;
        end
      end
      ST_FORCE: begin
        // One-cycle debug slot; the CPU is held off even if the debug master has gone away.
        w_stall     = w_cpuAct;
        w_waitNext  = 8'd0;
        w_stateNext = ST_ARB;
        if (i_dbg_req) begin
          w_dGrant   = 1'b1;
          w_forceHit = 1'b1;
          w_addr     = i_dbg_addr;
          w_wdata    = i_dbg_wdata;
          w_wren     = i_dbg_we;
        end
      end
      default: w_stateNext = ST_ARB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_ARB;
      r_waitCnt    <= 8'd0;
      r_cpuTag     <= 1'b0;
      r_dbgTag     <= 1'b0;
      r_statForced <= 16'd0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitNext;
      r_cpuTag  <= w_cGrant & i_cpu_rd & ~i_cpu_wr;
      r_dbgTag  <= w_dGrant & ~i_dbg_we;
      if (w_forceHit && (r_statForced != 16'hFFFF)) begin
        r_statForced <= r_statForced + 16'd1;
      end
    end
  end

  // Combinational outputs are gated by reset so nothing reaches the RAM while it is held.
  assign o_cpu_stall   = w_stall & i_rst_n;
  assign o_dbg_gnt     = w_dGrant & i_rst_n;
  assign o_ram_wren    = w_wren & i_rst_n;
  assign o_ram_addr    = i_rst_n ? w_addr : '0;
  assign o_ram_wdata   = i_rst_n ? w_wdata : '0;
  assign o_cpu_rvalid  = r_cpuTag;
  assign o_dbg_rvalid  = r_dbgTag;
  assign o_cpu_rdata   = r_cpuTag ? i_ram_q : '0;
  assign o_dbg_rdata   = r_dbgTag ? i_ram_q : '0;
  assign o_stat_forced = r_statForced;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a behavioural single-port RAM (1-cycle read latency).
module tb_dmem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpuRd, cpuWr, dbgReq, dbgWe;
  logic [5:0]  cpuAddr, dbgAddr;
  logic [31:0] cpuWdata, dbgWdata;
  logic        cpuStall, cpuRvalid, dbgGnt, dbgRvalid, ramWren;
  logic [31:0] cpuRdata, dbgRdata, ramWdata, ramQ;
  logic [5:0]  ramAddr;
  logic [15:0] statForced;
  logic [31:0] mem [64];
  int          assertCount;
  int          failCount;

  dmem_port_arbiter #(.AW(6), .DW(32), .STARVE_LIMIT(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_rd(cpuRd), .i_cpu_wr(cpuWr), .i_cpu_addr(cpuAddr), .i_cpu_wdata(cpuWdata),
    .o_cpu_stall(cpuStall), .o_cpu_rvalid(cpuRvalid), .o_cpu_rdata(cpuRdata),
    .i_dbg_req(dbgReq), .i_dbg_we(dbgWe), .i_dbg_addr(dbgAddr), .i_dbg_wdata(dbgWdata),
    .o_dbg_gnt(dbgGnt), .o_dbg_rvalid(dbgRvalid), .o_dbg_rdata(dbgRdata),
    .o_ram_addr(ramAddr), .o_ram_wdata(ramWdata), .o_ram_wren(ramWren),
    .i_ram_q(ramQ), .o_stat_forced(statForced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ramWren) mem[ramAddr] <= ramWdata;
    ramQ <= mem[ramAddr];
  end

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpuRd = 0; cpuWr = 0; cpuAddr = 0; cpuWdata = 0;
    dbgReq = 0; dbgWe = 0; dbgAddr = 0; dbgWdata = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    cpuWr = 1; cpuAddr = 6'd7; cpuWdata = 32'h1111_2222; dbgReq = 1; dbgAddr = 6'd8;
    @(negedge clk);
    assertCount++; if (cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL reset_stall got %b exp 0", cpuStall); end
    assertCount++; if (dbgGnt !== 1'b0) begin failCount++; $display("[TB] FAIL reset_gnt got %b exp 0", dbgGnt); end
    assertCount++; if (ramWren !== 1'b0) begin failCount++; $display("[TB] FAIL reset_wren got %b exp 0", ramWren); end
    assertCount++; if (ramAddr !== 6'd0) begin failCount++; $display("[TB] FAIL reset_addr got %0d exp 0", ramAddr); end
    assertCount++; if (ramWdata !== 32'd0) begin failCount++; $display("[TB] FAIL reset_wdata got %h exp 0", ramWdata); end
    assertCount++; if ({cpuRvalid, dbgRvalid} !== 2'b00) begin failCount++; $display("[TB] FAIL reset_rvalid got %b exp 00", {cpuRvalid, dbgRvalid}); end
    assertCount++; if (statForced !== 16'd0) begin failCount++; $display("[TB] FAIL reset_stat got %0d exp 0", statForced); end
    idleInputs();
    @(negedge clk);
    rst_n = 1;
    nextCycle();
  endtask

  task automatic test_cpu_only();
    cpuWr = 1; cpuAddr = 6'd5; cpuWdata = 32'hDEAD_BEEF;
    @(negedge clk);
    assertCount++; if (ramWren !== 1'b1) begin failCount++; $display("[TB] FAIL t1_wren got %b exp 1", ramWren); end
    assertCount++; if (ramAddr !== 6'd5 || ramWdata !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL t1_bus got %0d/%h exp 5/deadbeef", ramAddr, ramWdata); end
    assertCount++; if (cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL t1_stall_wr got %b exp 0", cpuStall); end
    nextCycle();
    cpuWr = 0; cpuRd = 1;
    @(negedge clk);
    assertCount++; if (ramWren !== 1'b0 || cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL t1_rd_issue wren/stall got %b%b exp 00", ramWren, cpuStall); end
    nextCycle();
    idleInputs();
    @(negedge clk);
    assertCount++; if (cpuRvalid !== 1'b1 || cpuRdata !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL t1_rdata got %b/%h exp 1/deadbeef", cpuRvalid, cpuRdata); end
    assertCount++; if (dbgRvalid !== 1'b0 || dbgRdata !== 32'd0) begin failCount++; $display("[TB] FAIL t1_dbg_quiet got %b/%h exp 0/0", dbgRvalid, dbgRdata); end
    nextCycle();
  endtask

  task automatic test_debug_idle();
    dbgReq = 1; dbgWe = 0; dbgAddr = 6'd5;
    @(negedge clk);
    assertCount++; if (dbgGnt !== 1'b1 || ramAddr !== 6'd5) begin failCount++; $display("[TB] FAIL t2_gnt got %b/%0d exp 1/5", dbgGnt, ramAddr); end
    nextCycle();
    idleInputs();
    @(negedge clk);
    assertCount++; if (dbgRvalid !== 1'b1 || dbgRdata !== 32'hDEAD_BEEF) begin failCount++; $display("[TB] FAIL t2_rdata got %b/%h exp 1/deadbeef", dbgRvalid, dbgRdata); end
    assertCount++; if (cpuRvalid !== 1'b0 || cpuRdata !== 32'd0) begin failCount++; $display("[TB] FAIL t2_cpu_quiet got %b/%h exp 0/0", cpuRvalid, cpuRdata); end
    nextCycle();
  endtask

  task automatic test_starvation();
    cpuRd = 1; cpuAddr = 6'd0;
    dbgReq = 1; dbgWe = 1; dbgAddr = 6'd9; dbgWdata = 32'h55;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      assertCount++; if (dbgGnt !== (n == 5)) begin failCount++; $display("[TB] FAIL t3_gnt_c%0d got %b exp %b", n, dbgGnt, (n == 5)); end
      assertCount++; if (cpuStall !== (n == 5)) begin failCount++; $display("[TB] FAIL t3_stall_c%0d got %b exp %b", n, cpuStall, (n == 5)); end
      if (n == 5) begin
        assertCount++; if (ramWren !== 1'b1 || ramAddr !== 6'd9 || ramWdata !== 32'h55) begin failCount++; $display("[TB] FAIL t3_force_bus got %b/%0d/%h exp 1/9/55", ramWren, ramAddr, ramWdata); end
      end
      nextCycle();
    end
    dbgReq = 0; dbgWe = 0; cpuAddr = 6'd9;
    @(negedge clk);
    assertCount++; if (statForced !== 16'd1) begin failCount++; $display("[TB] FAIL t3_stat got %0d exp 1", statForced); end
    assertCount++; if (cpuRvalid !== 1'b0) begin failCount++; $display("[TB] FAIL t3_stalled_rvalid got %b exp 0", cpuRvalid); end
    assertCount++; if (cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL t3_resume_stall got %b exp 0", cpuStall); end
    nextCycle();
    idleInputs();
    @(negedge clk);
    assertCount++; if (cpuRvalid !== 1'b1 || cpuRdata !== 32'h55) begin failCount++; $display("[TB] FAIL t3_readback got %b/%h exp 1/55", cpuRvalid, cpuRdata); end
    nextCycle();
  endtask

  task automatic test_rd_wr_both();
    cpuRd = 1; cpuWr = 1; cpuAddr = 6'd3; cpuWdata = 32'h1234_5678;
    @(negedge clk);
    assertCount++; if (ramWren !== 1'b1 || ramAddr !== 6'd3) begin failCount++; $display("[TB] FAIL t4_wren got %b/%0d exp 1/3", ramWren, ramAddr); end
    nextCycle();
    idleInputs();
    @(negedge clk);
    assertCount++; if (cpuRvalid !== 1'b0) begin failCount++; $display("[TB] FAIL t4_no_rvalid got %b exp 0", cpuRvalid); end
    cpuRd = 1; cpuAddr = 6'd3;
    nextCycle();
    idleInputs();
    @(negedge clk);
    assertCount++; if (cpuRvalid !== 1'b1 || cpuRdata !== 32'h1234_5678) begin failCount++; $display("[TB] FAIL t4_readback got %b/%h exp 1/12345678", cpuRvalid, cpuRdata); end
    nextCycle();
  endtask

  task automatic test_credit_reset();
    cpuRd = 1; cpuAddr = 6'd1; dbgWe = 1; dbgAddr = 6'd10; dbgWdata = 32'hA5;
    // Three denied cycles, one dropped cycle, then four more denials before the forced slot.
    for (int n = 1; n <= 9; n++) begin
      dbgReq = (n != 4);
      @(negedge clk);
      assertCount++; if (dbgGnt !== (n == 9)) begin failCount++; $display("[TB] FAIL t5_gnt_c%0d got %b exp %b", n, dbgGnt, (n == 9)); end
      nextCycle();
    end
    idleInputs();
    @(negedge clk);
    assertCount++; if (statForced !== 16'd2) begin failCount++; $display("[TB] FAIL t5_stat got %0d exp 2", statForced); end
    nextCycle();
  endtask

  task automatic test_reset_in_force();
    cpuRd = 1; cpuAddr = 6'd2; dbgReq = 1; dbgWe = 0; dbgAddr = 6'd5;
    for (int n = 1; n <= 4; n++) nextCycle();
    @(negedge clk);
    assertCount++; if (dbgGnt !== 1'b1 || cpuStall !== 1'b1) begin failCount++; $display("[TB] FAIL t6_in_force got %b%b exp 11", dbgGnt, cpuStall); end
    #1 rst_n = 0;
    #1;
    assertCount++; if (dbgGnt !== 1'b0 || cpuStall !== 1'b0 || ramAddr !== 6'd0 || ramWren !== 1'b0) begin failCount++; $display("[TB] FAIL t6_gated got %b%b/%0d/%b exp 00/0/0", dbgGnt, cpuStall, ramAddr, ramWren); end
    assertCount++; if (statForced !== 16'd0) begin failCount++; $display("[TB] FAIL t6_stat got %0d exp 0", statForced); end
    nextCycle();
    idleInputs();
    @(negedge clk);
    rst_n = 1;
    nextCycle();
    assertCount++; if (dbgRvalid !== 1'b0 || cpuRvalid !== 1'b0) begin failCount++; $display("[TB] FAIL t6_no_return got %b%b exp 00", dbgRvalid, cpuRvalid); end
    cpuRd = 1; dbgReq = 1;
    @(negedge clk);
    assertCount++; if (dbgGnt !== 1'b0 || cpuStall !== 1'b0) begin failCount++; $display("[TB] FAIL t6_state_arb got %b%b exp 00", dbgGnt, cpuStall); end
    nextCycle();
    idleInputs();
    nextCycle();
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    idleInputs();
    rst_n = 1;
    #2;
    test_reset();
    test_cpu_only();
    test_debug_idle();
    test_starvation();
    test_rd_wr_both();
    test_credit_reset();
    test_reset_in_force();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
